// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared types and default widths for the reservation station
//
// Purpose: package rs_pkg, imported by every reservation station file.
//   rs_entry_t : one scheduler slot (valid, op, qj, qk, vj, vk, a, dest)
//   TAG_NONE   : tag value meaning "operand value already present"
//   XLEN/OP_W/TAG_W : default data, opcode and tag widths

package rs_pkg;

    localparam int XLEN  = 32;
    localparam int OP_W  = 10;
    localparam int TAG_W = 5;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
        logic [XLEN-1:0]  a;
        logic [TAG_W-1:0] dest;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - dispatch, CDB and issue bundle of the reservation station
//
// Purpose: groups the decoder dispatch handshake, the common data bus snoop
// and the execution-unit issue handshake.
//   master : decoder / CDB / execution unit side (drives disp_*, cdb_*, issue_ready)
//   slave  : reservation station side (drives disp_ready, issue_*, occupancy)

interface reservation_station_if
    import rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = rs_pkg::TAG_W,
    parameter int XLEN  = rs_pkg::XLEN,
    parameter int OP_W  = rs_pkg::OP_W
);

    logic                     disp_valid;
    logic                     disp_ready;
    logic [OP_W-1:0]          disp_op;
    logic [TAG_W-1:0]         disp_qj;
    logic [TAG_W-1:0]         disp_qk;
    logic [XLEN-1:0]          disp_vj;
    logic [XLEN-1:0]          disp_vk;
    logic [XLEN-1:0]          disp_a;
    logic [TAG_W-1:0]         disp_dest;

    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [XLEN-1:0]          cdb_value;

    logic                     issue_valid;
    logic                     issue_ready;
    logic [OP_W-1:0]          issue_op;
    logic [XLEN-1:0]          issue_vj;
    logic [XLEN-1:0]          issue_vk;
    logic [XLEN-1:0]          issue_a;
    logic [TAG_W-1:0]         issue_dest;

    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        output disp_valid, disp_op, disp_qj, disp_qk, disp_vj, disp_vk, disp_a, disp_dest,
        output cdb_valid, cdb_tag, cdb_value,
        output issue_ready,
        input  disp_ready,
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_a, issue_dest,
        input  occupancy
    );

    modport slave (
        input  disp_valid, disp_op, disp_qj, disp_qk, disp_vj, disp_vk, disp_a, disp_dest,
        input  cdb_valid, cdb_tag, cdb_value,
        input  issue_ready,
        output disp_ready,
        output issue_valid, issue_op, issue_vj, issue_vk, issue_a, issue_dest,
        output occupancy
    );

endinterface

// File: rtl/reservation_station_age_matrix_arbiter.sv
// rtl/reservation_station_age_matrix_arbiter.sv - oldest-first arbiter built on an age matrix
//
// Purpose: age_q[i][j] = 1 means entry j was dispatched before entry i.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : synchronous clear of the whole matrix
//   alloc_valid/idx     : entry being allocated this cycle
//   valid_vec           : registered entry valid bits
//   free_mask           : one-hot entry being freed this cycle (or zero)
//   req                 : entries eligible for selection
//   grant               : one-hot oldest requesting entry

module age_matrix_arbiter
    import rs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       alloc_valid,
    input  logic [$clog2(DEPTH)-1:0]   alloc_idx,
    input  logic [DEPTH-1:0]           valid_vec,
    input  logic [DEPTH-1:0]           free_mask,
    input  logic [DEPTH-1:0]           req,
    output logic [DEPTH-1:0]           grant
);

    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] && ((age_q[i] & req) == '0);
        end
    end

    // Freed columns are cleared so rows never reference a dead entry; a new
    // entry is younger than every survivor, hence the row copy of valid_vec.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            age_d[r] = age_q[r] & ~free_mask;
        end
        if (alloc_valid) begin
            age_d[alloc_idx] = valid_vec & ~free_mask;
            for (int r = 0; r < DEPTH; r++) begin
                age_d[r][alloc_idx] = 1'b0;
            end
        end
        if (flush) begin
            for (int r = 0; r < DEPTH; r++) begin
                age_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                age_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                age_q[r] <= age_d[r];
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station feeding one execution unit
//
// Purpose: buffers decoded ops, captures pending operands from the CDB and
// issues the oldest fully-ready entry.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   flush      : synchronous discard of every entry (beats dispatch/issue/CDB)
//   bus        : reservation_station_if.slave (dispatch, CDB, issue, occupancy)

module reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = rs_pkg::TAG_W,
    parameter int XLEN  = rs_pkg::XLEN,
    parameter int OP_W  = rs_pkg::OP_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    reservation_station_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
        logic [XLEN-1:0]  a;
        logic [TAG_W-1:0] dest;
    } entry_t;

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             hold_q, hold_d;
    logic [DEPTH-1:0] held_q, held_d;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] arb_grant;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] free_mask;
    logic [IDX_W-1:0] alloc_idx;
    logic             disp_fire;
    logic             issue_fire;
    entry_t           sel;

    // Readiness uses registered operands only: a CDB capture becomes
    // issuable the following cycle.
    always_comb begin
        alloc_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries_q[i].valid;
            ready_vec[i] = entries_q[i].valid && (entries_q[i].qj == NO_TAG) &&
                           (entries_q[i].qk == NO_TAG);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    age_matrix_arbiter #(.DEPTH(DEPTH)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .alloc_valid (disp_fire),
        .alloc_idx   (alloc_idx),
        .valid_vec   (valid_vec),
        .free_mask   (free_mask),
        .req         (ready_vec),
        .grant       (arb_grant)
    );

    // While the execution unit stalls, the presented entry is pinned even if
    // an older entry wakes up meanwhile.
    always_comb begin
        grant = hold_q ? held_q : arb_grant;
        sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel = entries_q[i];
            end
        end
        bus.issue_valid = |grant;
        bus.issue_op    = sel.op;
        bus.issue_vj    = sel.vj;
        bus.issue_vk    = sel.vk;
        bus.issue_a     = sel.a;
        bus.issue_dest  = sel.dest;
        bus.disp_ready  = (occ_q < CNT_W'(DEPTH));
        disp_fire       = bus.disp_valid && bus.disp_ready;
        issue_fire      = bus.issue_valid && bus.issue_ready;
        free_mask       = issue_fire ? grant : '0;
    end

    assign bus.occupancy = occ_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].valid && bus.cdb_valid) begin
                if (entries_q[i].qj != NO_TAG && entries_q[i].qj == bus.cdb_tag) begin
                    entries_d[i].qj = NO_TAG;
                    entries_d[i].vj = bus.cdb_value;
                end
                if (entries_q[i].qk != NO_TAG && entries_q[i].qk == bus.cdb_tag) begin
                    entries_d[i].qk = NO_TAG;
                    entries_d[i].vk = bus.cdb_value;
                end
            end
            if (free_mask[i]) begin
                entries_d[i].valid = 1'b0;
            end
        end

        if (disp_fire) begin
            entries_d[alloc_idx].valid = 1'b1;
            entries_d[alloc_idx].op    = bus.disp_op;
            entries_d[alloc_idx].a     = bus.disp_a;
            entries_d[alloc_idx].dest  = bus.disp_dest;
            entries_d[alloc_idx].qj    = bus.disp_qj;
            entries_d[alloc_idx].vj    = bus.disp_vj;
            entries_d[alloc_idx].qk    = bus.disp_qk;
            entries_d[alloc_idx].vk    = bus.disp_vk;
            // Result broadcast in the dispatch cycle would otherwise be missed.
            if (bus.cdb_valid && bus.disp_qj != NO_TAG && bus.disp_qj == bus.cdb_tag) begin
                entries_d[alloc_idx].qj = NO_TAG;
                entries_d[alloc_idx].vj = bus.cdb_value;
            end
            if (bus.cdb_valid && bus.disp_qk != NO_TAG && bus.disp_qk == bus.cdb_tag) begin
                entries_d[alloc_idx].qk = NO_TAG;
                entries_d[alloc_idx].vk = bus.cdb_value;
            end
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
        end

        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        end

        hold_d = bus.issue_valid && !bus.issue_ready && !flush;
        held_d = grant;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            occ_q  <= '0;
            hold_q <= 1'b0;
            held_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            occ_q  <= occ_d;
            hold_q <= hold_d;
            held_q <= held_d;
        end
    end

endmodule
